switch_allocator: RTL

//  Per-output-port round-robin allocator for one mesh router. It takes the one-hot route

---
 rtl/switch_allocator_if.sv | 23 ++
 rtl/switch_allocator.sv | 118 +++++++++++
 2 files changed

// File: rtl/switch_allocator_if.sv
// Handshake bundle between the five routing blocks and the switch allocator.
// Ports: req[i][o], out_ready[o] (to allocator); grant[i][o], out_valid[o],
//        out_sel[o], in_ack[i] (from allocator). Index order 0=N 1=E 2=S 3=W 4=L.
interface switch_allocator_if #(
   parameter int NUM_PORTS = 5
);
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;
   logic [NUM_PORTS-1:0]                out_ready;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0]                out_valid;
   logic [NUM_PORTS-1:0][2:0]           out_sel;
   logic [NUM_PORTS-1:0]                in_ack;

   modport master (
      output req, out_ready,
      input  grant, out_valid, out_sel, in_ack
   );

   modport slave (
      input  req, out_ready,
      output grant, out_valid, out_sel, in_ack
   );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin wormhole allocator for a 5-port mesh router.
// Ports: clk, rst (async, active-high), sw (switch_allocator_if.slave):
//   req[i][o] in, out_ready[o] in, grant[i][o] out (reg), out_valid[o] out,
//   out_sel[o] out (reg), in_ack[i] out.
// Optional build macro ALLOC_STALL_TIMEOUT_EN: force release of an output
// after STALL_LIMIT continuous backpressured cycles.
module switch_allocator #(
   parameter int NUM_PORTS   = 5,
   parameter int STALL_LIMIT = 64
) (
   input logic               clk,
   input logic               rst,
   switch_allocator_if.slave sw
);
   localparam int SW = 3;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                              state [NUM_PORTS];
   logic [SW-1:0]                       ptr   [NUM_PORTS];
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_q;
   logic [NUM_PORTS-1:0][SW-1:0]        sel_q;

   logic [NUM_PORTS-1:0]                hold_req;
   logic [NUM_PORTS-1:0]                win_found;
   logic [NUM_PORTS-1:0][SW-1:0]        win;
   logic [NUM_PORTS-1:0]                release_now;
   logic [NUM_PORTS-1:0]                ack;

   if (STALL_LIMIT < 2) begin : g_bad_limit
      $error("STALL_LIMIT must be at least 2");
   end

`ifdef ALLOC_STALL_TIMEOUT_EN
   localparam int CW = $clog2(STALL_LIMIT) + 1;
   logic [CW-1:0] stall_cnt [NUM_PORTS];
`endif

   // Holder's request and the rotating first-at-or-after-ptr search.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         hold_req[o]  = (state[o] == LOCKED) && sw.req[sel_q[o]][o];
         win_found[o] = 1'b0;
         win[o]       = '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (!win_found[o] &&
                sw.req[(int'(ptr[o]) + k) % NUM_PORTS][o]) begin
               win_found[o] = 1'b1;
               win[o]       = SW'((int'(ptr[o]) + k) % NUM_PORTS);
            end
         end
`ifdef ALLOC_STALL_TIMEOUT_EN
         release_now[o] = (state[o] == LOCKED) &&
                          (!hold_req[o] ||
                           (!sw.out_ready[o] &&
                            stall_cnt[o] == CW'(STALL_LIMIT - 1)));
`else
         release_now[o] = (state[o] == LOCKED) && !hold_req[o];
`endif
      end
   end

   // A row is one-hot, so at most one output term per input is live.
   always_comb begin
      ack = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            ack[i] = ack[i] |
                     (grant_q[i][o] & sw.req[i][o] & sw.out_ready[o]);
         end
      end
   end

   assign sw.grant     = grant_q;
   assign sw.out_sel   = sel_q;
   assign sw.out_valid = hold_req;
   assign sw.in_ack    = ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q <= '0;
         sel_q   <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            state[o] <= IDLE;
            ptr[o]   <= '0;
`ifdef ALLOC_STALL_TIMEOUT_EN
            stall_cnt[o] <= '0;
`endif
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            unique case (state[o])
               IDLE: begin
                  if (win_found[o]) begin
                     state[o]           <= LOCKED;
                     grant_q[win[o]][o] <= 1'b1;
                     sel_q[o]           <= win[o];
                  end
               end
               LOCKED: begin
                  if (release_now[o]) begin
                     state[o]             <= IDLE;
                     grant_q[sel_q[o]][o] <= 1'b0;
                     ptr[o] <= (sel_q[o] == SW'(NUM_PORTS - 1)) ?
                               '0 : sel_q[o] + 1'b1;
                  end
               end
            endcase
`ifdef ALLOC_STALL_TIMEOUT_EN
            if (release_now[o] || !hold_req[o] || sw.out_ready[o])
               stall_cnt[o] <= '0;
            else
               stall_cnt[o] <= stall_cnt[o] + 1'b1;
`endif
         end
      end
   end
endmodule
